// File: rtl/seq_magnitude_comparator_pkg.sv
// ---------------------------------------------------------------------------
// cmp_pkg
// Shared definitions for the slice-serial magnitude comparator.
//   cmp_state_t : controller states (IDLE, RUN, DONE)
//   RES_EQ/GT/LT: one-hot result encodings, bit order {greater, equal, less}
// ---------------------------------------------------------------------------
package cmp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } cmp_state_t;

   localparam logic [2:0] RES_GT = 3'b100;
   localparam logic [2:0] RES_EQ = 3'b010;
   localparam logic [2:0] RES_LT = 3'b001;

endpackage

// File: rtl/seq_magnitude_comparator_if.sv
// ---------------------------------------------------------------------------
// seq_magnitude_comparator_if
// Request/response bundle of the comparator.
//   start, signed_mode, a, b : request side (driven by the master)
//   busy, done               : handshake status (driven by the comparator)
//   equal, greater, less     : registered one-hot result of the last compare
// Modports: master (requester), slave (comparator).
// ---------------------------------------------------------------------------
interface seq_magnitude_comparator_if #(
   parameter int WIDTH = 16
);

   logic             start;
   logic             signed_mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             equal;
   logic             greater;
   logic             less;

   modport master (
      output start, signed_mode, a, b,
      input  busy, done, equal, greater, less
   );

   modport slave (
      input  start, signed_mode, a, b,
      output busy, done, equal, greater, less
   );

endinterface

// File: rtl/seq_magnitude_comparator_slice_cmp.sv
// ---------------------------------------------------------------------------
// slice_cmp
// Purely combinational unsigned compare of one SLICE-bit slice.
//   x, y : slice operands
//   gt   : x > y
//   lt   : x < y   (neither set means the slices are equal)
// ---------------------------------------------------------------------------
module slice_cmp #(
   parameter int SLICE = 4
) (
   input  logic [SLICE-1:0] x,
   input  logic [SLICE-1:0] y,
   output logic             gt,
   output logic             lt
);

   // Signed operands are pre-biased by the top level, so an unsigned
   // relation is all this slice ever needs.
   assign gt = (x > y);
   assign lt = (x < y);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// seq_magnitude_comparator
// Slice-serial A vs B magnitude comparator, MSB slice first, with early
// exit on the first differing slice. Signed or unsigned per request.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of seq_magnitude_comparator_if
//          start/signed_mode/a/b in, busy/done/equal/greater/less out
// Latency from the accepting edge is the 1-based position of the first
// differing slice counted from the MSB, or NSLICES for equal operands.
// ---------------------------------------------------------------------------
module seq_magnitude_comparator
   import cmp_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input logic                    clk,
   input logic                    rst,
   seq_magnitude_comparator_if.slave bus
);

   localparam int NSLICES = WIDTH / SLICE;
   localparam int IDXW    = (NSLICES > 1) ? $clog2(NSLICES) : 1;
   localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);

   // Reject parameter combinations that cannot be sliced evenly.
   if ((SLICE < 1) || (SLICE > WIDTH) || ((WIDTH % SLICE) != 0)) begin : g_param_check
      $error("seq_magnitude_comparator: WIDTH must be a positive multiple of SLICE");
   end

   cmp_state_t       state;
   cmp_state_t       nextState;
   logic [IDXW-1:0]  idx;
   logic [WIDTH-1:0] opA;
   logic [WIDTH-1:0] opB;
   logic [2:0]       result;
   logic [SLICE-1:0] sliceA;
   logic [SLICE-1:0] sliceB;
   logic             sliceGt;
   logic             sliceLt;
   logic             lastSlice;
   logic             accept;

   // A new request is taken whenever no compare is in flight, which
   // includes the DONE cycle and gives bubble-free back-to-back compares.
   assign accept    = bus.start && (state != RUN);
   assign lastSlice = (idx == '0);

   // Select the slice currently under test from the captured operands.
   assign sliceA = opA[int'(idx) * SLICE +: SLICE];
   assign sliceB = opB[int'(idx) * SLICE +: SLICE];

   slice_cmp #(
      .SLICE (SLICE)
   ) u_slice_cmp (
      .x  (sliceA),
      .y  (sliceB),
      .gt (sliceGt),
      .lt (sliceLt)
   );

   // Next-state logic: RUN finishes on the first unequal slice or once
   // the least significant slice has been found equal.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (bus.start) begin
               nextState = RUN;
            end
         end
         RUN: begin
            if (sliceGt || sliceLt || lastSlice) begin
               nextState = DONE;
            end
         end
         DONE: begin
            nextState = bus.start ? RUN : IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // State register; a reset mid-compare simply drops the compare.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Operand capture, slice index and result registers. Flipping the sign
   // bit of both operands maps two's-complement order onto unsigned order,
   // so the serial walk itself is always unsigned. The result register is
   // written only on the completing edge, so flags hold during RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opA    <= '0;
         opB    <= '0;
         idx    <= '0;
         result <= '0;
      end else if (accept) begin
         opA <= bus.signed_mode ? (bus.a ^ SIGN_MASK) : bus.a;
         opB <= bus.signed_mode ? (bus.b ^ SIGN_MASK) : bus.b;
         idx <= IDXW'(NSLICES - 1);
      end else if (state == RUN) begin
         if (sliceGt) begin
            result <= RES_GT;
         end else if (sliceLt) begin
            result <= RES_LT;
         end else if (lastSlice) begin
            result <= RES_EQ;
         end else begin
            idx <= idx - 1'b1;
         end
      end
   end

   // Status and result outputs are decoded straight from registers.
   assign bus.busy    = (state == RUN);
   assign bus.done    = (state == DONE);
   assign bus.greater = result[2];
   assign bus.equal   = result[1];
   assign bus.less    = result[0];

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// tb_seq_magnitude_comparator
// Scoreboard bench for seq_magnitude_comparator (WIDTH=16, SLICE=4).
// Stimulus pushes the expected flags and done time for every accepted
// request; an independent monitor checks the DUT on every falling edge.
// ---------------------------------------------------------------------------
module tb_seq_magnitude_comparator;

   localparam int WIDTH   = 16;
   localparam int SLICE   = 4;
   localparam int NSLICES = WIDTH / SLICE;
   localparam int PERIOD  = 10;

   typedef struct {
      logic [2:0] res;
      time        doneTime;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   int         checks = 0;
   int         errors = 0;
   exp_t       sb[$];
   logic [2:0] lastFlags = 3'b000;

   seq_magnitude_comparator_if #(.WIDTH(WIDTH)) bus ();

   seq_magnitude_comparator #(
      .WIDTH (WIDTH),
      .SLICE (SLICE)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock.
   always #(PERIOD / 2) clk = ~clk;

   // One comparison: counts it and reports a mismatch.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, actual, required, $time);
      end
   endtask

   // Reference: plain integer compare for the flags; latency from the
   // highest differing bit position of the raw operands.
   function automatic void refModel(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                    input logic m, output logic [2:0] res, output int k);
      int xi;
      int yi;
      int p;
      logic [WIDTH-1:0] diff;
      if (m) begin
         xi = int'($signed(x));
         yi = int'($signed(y));
      end else begin
         xi = int'(x);
         yi = int'(y);
      end
      res  = {xi > yi, xi == yi, xi < yi};
      diff = x ^ y;
      p    = -1;
      for (int i = 0; i < WIDTH; i++) begin
         if (diff[i]) p = i;
      end
      k = (p < 0) ? NSLICES : (NSLICES - p / SLICE);
   endfunction

   // Issue one request from a falling edge with busy=0; returns at the
   // falling edge after the accepting edge.
   task automatic applyStimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb2, input logic mode);
      exp_t e;
      int   k;
      refModel(ta, tb2, mode, e.res, k);
      bus.a           = ta;
      bus.b           = tb2;
      bus.signed_mode = mode;
      bus.start       = 1'b1;
      @(posedge clk);
      e.doneTime = $time + time'(k * PERIOD + PERIOD / 2);
      sb.push_back(e);
      #1;
      bus.start       = 1'b0;
      bus.a           = WIDTH'($urandom);
      bus.b           = WIDTH'($urandom);
      bus.signed_mode = 1'($urandom_range(0, 1));
      @(negedge clk);
   endtask

   // Advance falling edges until done is seen, with a cycle budget.
   task automatic waitDone();
      for (int i = 0; i < NSLICES + 4; i++) begin
         if (bus.done) return;
         @(negedge clk);
      end
      checkOutput("wait_done_timeout", 32'(bus.done), 32'd1);
   endtask

   // Monitor: pops the scoreboard on done, otherwise checks that busy
   // matches the outstanding request and that the flags are held.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (bus.done) begin
               if (sb.size() == 0) begin
                  checkOutput("unexpected_done", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  checkOutput("result_flags", 32'({bus.greater, bus.equal, bus.less}), 32'(e.res));
                  checkOutput("done_time", 32'($time), 32'(e.doneTime));
                  checkOutput("busy_in_done", 32'(bus.busy), 32'd0);
                  lastFlags = e.res;
               end
            end else begin
               checkOutput("flags_held", 32'({bus.greater, bus.equal, bus.less}), 32'(lastFlags));
               if (sb.size() != 0) begin
                  if ($time > sb[0].doneTime) begin
                     checkOutput("missing_done", 32'd0, 32'd1);
                     void'(sb.pop_front());
                  end else begin
                     checkOutput("busy_running", 32'(bus.busy), 32'd1);
                  end
               end else begin
                  checkOutput("busy_idle", 32'(bus.busy), 32'd0);
               end
            end
         end
      end
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main stimulus sequence.
   initial begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      bus.start       = 1'b0;
      bus.signed_mode = 1'b0;
      bus.a           = '0;
      bus.b           = '0;

      #1 rst = 1'b1;
      #2;
      checkOutput("reset_busy", 32'(bus.busy), 32'd0);
      checkOutput("reset_done", 32'(bus.done), 32'd0);
      checkOutput("reset_flags", 32'({bus.greater, bus.equal, bus.less}), 32'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);

      // Directed cases, each issued in the done cycle of the previous one.
      applyStimulus(16'h1234, 16'h1234, 1'b0);
      waitDone();
      applyStimulus(16'h8000, 16'h7FFF, 1'b0);
      waitDone();
      applyStimulus(16'h8000, 16'h7FFF, 1'b1);
      waitDone();
      applyStimulus(16'h12A4, 16'h12B4, 1'b0);
      waitDone();
      applyStimulus(16'hFFFF, 16'h0001, 1'b1);
      waitDone();
      applyStimulus(16'hFFFF, 16'hFFFE, 1'b1);
      waitDone();
      applyStimulus(16'h0001, 16'h0002, 1'b0);
      waitDone();
      @(negedge clk);

      // Start while busy must be ignored.
      applyStimulus(16'h0001, 16'h0003, 1'b0);
      bus.a           = 16'hF000;
      bus.b           = 16'h0000;
      bus.signed_mode = 1'b1;
      bus.start       = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(negedge clk);
      waitDone();
      @(negedge clk);

      // Asynchronous reset in the middle of a compare.
      applyStimulus(16'h1111, 16'h1110, 1'b0);
      @(negedge clk);
      #2 rst = 1'b1;
      sb.delete();
      lastFlags = 3'b000;
      #1;
      checkOutput("midrun_reset_busy", 32'(bus.busy), 32'd0);
      checkOutput("midrun_reset_done", 32'(bus.done), 32'd0);
      checkOutput("midrun_reset_flags", 32'({bus.greater, bus.equal, bus.less}), 32'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      applyStimulus(16'h00FF, 16'h00FE, 1'b0);
      waitDone();

      // Randomised compares covering every early-exit position.
      repeat (40) begin
         ra = WIDTH'($urandom);
         rb = ra ^ WIDTH'(WIDTH'($urandom) >> $urandom_range(0, WIDTH));
         applyStimulus(ra, rb, 1'($urandom_range(0, 1)));
         waitDone();
         if ($urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
      end

      repeat (3) @(negedge clk);
      checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
